// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// well-known keyboard command/response bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
// Flops reset high so a released (pulled-up) line never looks like an edge.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Bring the asynchronous pin into the clk domain and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over
// the shared open-collector clk/data pins (oe=1 pulls the pin low).
// Optional build macro PS2_TX_RETRY_EN: a failed first attempt (no ack or
// stalled device clock) is silently retried once with the same byte; the error
// pulse is only raised if the retry also fails.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 743,
    parameter int TIMEOUT_CYCLES = 148500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data_i),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    ps2_state_t        state;
    logic [7:0]        byte_q;
    logic              parity_q;
    logic [2:0]        bit_idx;
    logic [INH_W-1:0]  inh_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              retry_now;

`ifdef PS2_TX_RETRY_EN
    logic retried;
    assign retry_now = ~retried;
`else
    assign retry_now = 1'b0;
`endif

    // Transmit FSM: inhibit, request-to-send, shift bits on device clock falls, check ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
            rx_inhibit  <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            bit_idx     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
`ifdef PS2_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        byte_q      <= tx_data;
                        parity_q    <= odd_parity(tx_data);
                        bit_idx     <= '0;
                        inh_cnt     <= '0;
                        tx_ready    <= 1'b0;
                        rx_inhibit  <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retried     <= 1'b0;
`endif
                    end
                end
                ST_INHIBIT: begin
                    // Start bit goes low while the clock is still held, on the final inhibit cycle.
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b1;
                    to_cnt      <= '0;
                    state       <= ST_DATA;
                end
                default: begin
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Device clock stalled: takes priority over any fall this cycle.
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (retry_now) begin
                            ps2_clk_oe <= 1'b1;
                            inh_cnt    <= '0;
                            bit_idx    <= '0;
                            state      <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retried    <= 1'b1;
`endif
                        end else begin
                            timeout    <= 1'b1;
                            tx_ready   <= 1'b1;
                            rx_inhibit <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end else begin
                        if (clk_fall) begin
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        case (state)
                            ST_DATA: begin
                                if (clk_fall) begin
                                    ps2_data_oe <= ~byte_q[bit_idx];
                                    bit_idx     <= bit_idx + 1'b1;
                                    if (bit_idx == 3'd7) begin
                                        state <= ST_PARITY;
                                    end
                                end
                            end
                            ST_PARITY: begin
                                if (clk_fall) begin
                                    ps2_data_oe <= ~parity_q;
                                    state       <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                if (clk_fall) begin
                                    ps2_data_oe <= 1'b0;
                                    state       <= ST_ACK;
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    if (!data_level) begin
                                        state <= ST_WAIT_IDLE;
                                    end else if (retry_now) begin
                                        ps2_clk_oe  <= 1'b1;
                                        ps2_data_oe <= 1'b0;
                                        inh_cnt     <= '0;
                                        bit_idx     <= '0;
                                        state       <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                                        retried     <= 1'b1;
`endif
                                    end else begin
                                        ack_err    <= 1'b1;
                                        tx_ready   <= 1'b1;
                                        rx_inhibit <= 1'b0;
                                        state      <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_level && data_level) begin
                                    done       <= 1'b1;
                                    tx_ready   <= 1'b1;
                                    rx_inhibit <= 1'b0;
                                    state      <= ST_IDLE;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard drives the device clock
// (scaled-down period) and reads the frame back bit by bit on rising edges.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 743;
    localparam int TO  = 2500;
    localparam int H   = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, done, ack_err, timeout, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_pin, data_pin;

    // Open-collector wired-AND of host and device drivers.
    assign clk_pin  = ~ps2_clk_oe & dev_clk;
    assign data_pin = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_i   (clk_pin),
        .ps2_data_i  (data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Event monitor: pulse counts, inhibit window shape, key timestamps.
    int   n_done = 0, n_err = 0, n_to = 0, bad_pulse = 0;
    int   run = 0, inh_len = 0, rel_cyc = 0, rise_cyc = 0, done_cyc = 0, to_cyc = 0;
    logic prev_clk_oe = 1'b0, d_last = 1'b0, d_prev = 1'b0;
    logic inh_last = 1'b0, inh_before = 1'b0, rel_data = 1'b0;

    always @(negedge clk) begin
        prev_clk_oe <= ps2_clk_oe;
        if (ps2_clk_oe) begin
            run    <= prev_clk_oe ? run + 1 : 1;
            d_last <= ps2_data_oe;
            d_prev <= d_last;
        end else if (prev_clk_oe) begin
            inh_len    <= run;
            inh_last   <= d_last;
            inh_before <= d_prev;
            rel_cyc    <= cyc;
            rel_data   <= ps2_data_oe;
        end
        if (ps2_clk_oe && !prev_clk_oe) rise_cyc <= cyc;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (ack_err) n_err <= n_err + 1;
        if (timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if ((done & ack_err) | (done & timeout) | (ack_err & timeout) |
            ((done | ack_err | timeout) & ~tx_ready))
            bad_pulse <= bad_pulse + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected 10 bits seen on rising edges 1..10: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        check("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard side of one host-to-device frame; stops after n_rises clock pulses.
    task automatic dev_frame(input bit ack_low, input int n_rises,
                             output logic [9:0] bits, output bit ok);
        int k;
        ok   = 1'b0;
        bits = '0;
        k = 0;
        while (clk_pin !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (clk_pin !== 1'b0) return;
        k = 0;
        while (!(clk_pin === 1'b1 && data_pin === 1'b0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!(clk_pin === 1'b1 && data_pin === 1'b0)) return;
        ok = 1'b1;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i > n_rises) return;
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = data_pin;
            if (i == 10 && ack_low) begin
                repeat (H/2) @(negedge clk);
                dev_data = 1'b0;
                repeat (H/2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        bit         ok;
        logic [7:0] b, a;
        int         exp_done, exp_err, exp_to, snap, k;

        exp_done = 0;
        exp_err  = 0;
        exp_to   = 0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_inhibit", rx_inhibit, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_pulses", {done, ack_err, timeout}, 0);
        rst = 1'b0;
        cycles(3);

        // Set-LEDs command with ack
        send(PS2_CMD_SET_LEDS);
        cycles(5);
        check("busy_tx_ready", tx_ready, 0);
        check("busy_rx_inhibit", rx_inhibit, 1);
        check("busy_clk_oe", ps2_clk_oe, 1);
        check("busy_data_oe", ps2_data_oe, 0);
        dev_frame(1'b1, 11, bits, ok);
        check("ed_start_seen", ok, 1);
        check("ed_frame", bits, 10'h3ED);
        check("inhibit_len", inh_len, INH);
        check("inhibit_data_last", inh_last, 1);
        check("inhibit_data_before", inh_before, 0);
        check("release_data_oe", rel_data, 1);
        cycles(20);
        exp_done++;
        check("ed_done", n_done, exp_done);
        check("ed_err", n_err, exp_err);
        check("ed_to", n_to, exp_to);
        check("ed_idle_ready", tx_ready, 1);
        check("ed_idle_inhibit", rx_inhibit, 0);

        // Random bytes
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom);
            send(b);
            dev_frame(1'b1, 11, bits, ok);
            check("rand_start_seen", ok, 1);
            check("rand_frame", bits, frame_of(b));
            cycles(20);
            exp_done++;
            check("rand_done", n_done, exp_done);
        end

        // Device never acks
        send(PS2_CMD_ECHO);
        dev_frame(1'b0, 11, bits, ok);
        check("noack_frame", bits, frame_of(PS2_CMD_ECHO));
`ifdef PS2_TX_RETRY_EN
        cycles(10);
        check("retry_no_pulse_yet", n_err, exp_err);
        check("retry_rx_inhibit", rx_inhibit, 1);
        dev_frame(1'b0, 11, bits, ok);
        check("retry_frame", bits, frame_of(PS2_CMD_ECHO));
`endif
        cycles(20);
        exp_err++;
        check("noack_err", n_err, exp_err);
        check("noack_done", n_done, exp_done);

        // Device never clocks after release
        send(PS2_CMD_RESET);
        k = 0;
        while (n_to == exp_to && k < 3 * (TO + INH)) begin
            @(negedge clk);
            k++;
        end
        exp_to++;
        check("to_pulse", n_to, exp_to);
        check("to_latency", to_cyc - rel_cyc, TO);
        check("to_clk_oe", ps2_clk_oe, 0);
        check("to_data_oe", ps2_data_oe, 0);
        check("to_tx_ready", tx_ready, 1);

        // Reset in the middle of the data bits
        b = 8'h5A;
        send(b);
        dev_frame(1'b1, 4, bits, ok);
        check("mid_partial_bits", bits[3:0], b[3:0]);
        snap = n_done + n_err + n_to;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_rx_inhibit", rx_inhibit, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        cycles(30);
        check("mid_rst_no_pulse", n_done + n_err + n_to, snap);

        // Fresh command after the abort
        send(PS2_CMD_RESET);
        dev_frame(1'b1, 11, bits, ok);
        check("ff_frame", bits, frame_of(PS2_CMD_RESET));
        cycles(20);
        exp_done++;
        check("ff_done", n_done, exp_done);

        // Held request with changing data; next byte taken on the done cycle
        a = 8'($urandom);
        b = 8'($urandom);
        wait_ready();
        tx_data  = a;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = ~a;
        cycles(100);
        tx_data = b;
        dev_frame(1'b1, 11, bits, ok);
        check("b2b_first_frame", bits, frame_of(a));
        cycles(20);
        exp_done++;
        check("b2b_first_done", n_done, exp_done);
        check("b2b_back_to_back", rise_cyc - done_cyc, 1);
        check("b2b_busy", tx_ready, 0);
        tx_valid = 1'b0;
        dev_frame(1'b1, 11, bits, ok);
        check("b2b_second_frame", bits, frame_of(b));
        cycles(20);
        exp_done++;
        check("b2b_second_done", n_done, exp_done);
        check("b2b_idle", tx_ready, 1);

        check("pulse_rules", bad_pulse, 0);
        check("total_err", n_err, exp_err);
        check("total_to", n_to, exp_to);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(2000000);
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
